// File: rtl/fp_cmp_sel_pipe_if.sv
`default_nettype none
// fp_cmp_sel_pipe_if: request/response bundle of the FP32 compare/select pipe.
// Revision 1.0 - initial release.
interface fp_cmp_sel_pipe_if #(
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [4:0]       out_fflags;
  logic [TAG_W-1:0] out_tag;
  logic             flush;
  logic             fflags_clr;
  logic [4:0]       sticky_fflags;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready, flush, fflags_clr,
    input  in_ready, out_valid, out_data, out_fflags, out_tag, sticky_fflags
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready, flush, fflags_clr,
    output in_ready, out_valid, out_data, out_fflags, out_tag, sticky_fflags
  );
endinterface
`default_nettype wire

// File: rtl/fp_cmp_sel_pipe.sv
`default_nettype none
// fp_cmp_sel_pipe: two-stage FP32 FEQ/FLT/FLE/FMIN/FMAX unit with sticky fflags.
// Revision 1.0 - initial release.
module fp_cmp_sel_pipe #(
  parameter int TAG_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  fp_cmp_sel_pipe_if.slave  bus
);

  localparam logic [2:0]  OP_FEQ    = 3'd0;
  localparam logic [2:0]  OP_FLT    = 3'd1;
  localparam logic [2:0]  OP_FLE    = 3'd2;
  localparam logic [2:0]  OP_FMIN   = 3'd3;
  localparam logic [2:0]  OP_FMAX   = 3'd4;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // Pipeline control
  logic s1_valid;
  logic s2_valid;
  logic s1_en;
  logic s2_en;
  logic accept;
  logic fire;

  assign s2_en       = !s2_valid || bus.out_ready;
  assign s1_en       = !s1_valid || s2_en;
  assign accept      = bus.in_valid && s1_en;
  assign fire        = s2_valid && bus.out_ready;
  assign bus.in_ready = s1_en;

  // Operand decode and compare on the incoming request
  logic a_nan;
  logic b_nan;
  logic a_snan;
  logic b_snan;
  logic a_zero;
  logic b_zero;
  logic cmp_eq;
  logic cmp_lt;
  logic cmp_nv;

  always_comb begin
    a_nan  = (bus.in_a[30:23] == 8'hFF) && (bus.in_a[22:0] != 23'd0);
    b_nan  = (bus.in_b[30:23] == 8'hFF) && (bus.in_b[22:0] != 23'd0);
    a_snan = a_nan && !bus.in_a[22];
    b_snan = b_nan && !bus.in_b[22];
    a_zero = (bus.in_a[30:0] == 31'd0);
    b_zero = (bus.in_b[30:0] == 31'd0);
    cmp_eq = 1'b0;
    cmp_lt = 1'b0;
    if (!(a_nan || b_nan)) begin
      if (a_zero && b_zero) begin
        cmp_eq = 1'b1;
      end else begin
        cmp_eq = (bus.in_a == bus.in_b);
        if (bus.in_a[31] != bus.in_b[31]) begin
          cmp_lt = bus.in_a[31];
        end else if (bus.in_a[31]) begin
          cmp_lt = (bus.in_a[30:0] > bus.in_b[30:0]);
        end else begin
          cmp_lt = (bus.in_a[30:0] < bus.in_b[30:0]);
        end
      end
    end
    case (bus.in_op)
      OP_FEQ, OP_FMIN, OP_FMAX: cmp_nv = a_snan || b_snan;
      OP_FLT, OP_FLE:           cmp_nv = a_nan || b_nan;
      default:                  cmp_nv = 1'b0;
    endcase
  end

  // Stage 1 registers
  logic [2:0]       s1_op;
  logic [31:0]      s1_a;
  logic [31:0]      s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_a_nan;
  logic             s1_b_nan;
  logic             s1_a_zero;
  logic             s1_b_zero;
  logic             s1_eq;
  logic             s1_lt;
  logic             s1_nv;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_op     <= 3'd0;
      s1_a      <= 32'd0;
      s1_b      <= 32'd0;
      s1_tag    <= '0;
      s1_a_nan  <= 1'b0;
      s1_b_nan  <= 1'b0;
      s1_a_zero <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_eq     <= 1'b0;
      s1_lt     <= 1'b0;
      s1_nv     <= 1'b0;
    end else if (accept) begin
      s1_op     <= bus.in_op;
      s1_a      <= bus.in_a;
      s1_b      <= bus.in_b;
      s1_tag    <= bus.in_tag;
      s1_a_nan  <= a_nan;
      s1_b_nan  <= b_nan;
      s1_a_zero <= a_zero;
      s1_b_zero <= b_zero;
      s1_eq     <= cmp_eq;
      s1_lt     <= cmp_lt;
      s1_nv     <= cmp_nv;
    end
  end

  // Result selection from stage 1
  logic        a_first;
  logic [31:0] result;
  logic [4:0]  result_flags;

  always_comb begin
    // -0 orders below +0 for min/max only; the compare itself treats them equal
    a_first      = s1_lt || (s1_a_zero && s1_b_zero && s1_a[31] && !s1_b[31]);
    result       = 32'd0;
    result_flags = {s1_nv, 4'd0};
    case (s1_op)
      OP_FEQ: result = {31'd0, s1_eq};
      OP_FLT: result = {31'd0, s1_lt};
      OP_FLE: result = {31'd0, s1_lt || s1_eq};
      OP_FMIN, OP_FMAX: begin
        if (s1_a_nan && s1_b_nan) begin
          result = CANON_NAN;
        end else if (s1_a_nan) begin
          result = s1_b;
        end else if (s1_b_nan) begin
          result = s1_a;
        end else if (s1_op == OP_FMIN) begin
          result = a_first ? s1_a : s1_b;
        end else begin
          result = a_first ? s1_b : s1_a;
        end
      end
      default: result = 32'd0;
    endcase
  end

  // Stage 2 registers drive the outputs directly
  logic [31:0]      s2_data;
  logic [4:0]       s2_fflags;
  logic [TAG_W-1:0] s2_tag;
  logic [4:0]       sticky;

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_data   <= 32'd0;
      s2_fflags <= 5'd0;
      s2_tag    <= '0;
    end else if (s2_en && s1_valid) begin
      s2_data   <= result;
      s2_fflags <= result_flags;
      s2_tag    <= s1_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= bus.in_valid;
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
      end
    end
  end

  // A result leaving on the same edge as a clear is kept, not lost
  always_ff @(posedge clock) begin
    if (reset) begin
      sticky <= 5'd0;
    end else if (bus.fflags_clr) begin
      sticky <= fire ? s2_fflags : 5'd0;
    end else if (fire) begin
      sticky <= sticky | s2_fflags;
    end
  end

  assign bus.out_valid     = s2_valid;
  assign bus.out_data      = s2_data;
  assign bus.out_fflags    = s2_fflags;
  assign bus.out_tag       = s2_tag;
  assign bus.sticky_fflags = sticky;

endmodule
`default_nettype wire
